// File: rtl/adau_spi_master_if.sv
// Command handshake between the init sequencer and the ADAU1761 SPI master.
// Sequencer side uses modport master, the SPI engine uses modport slave.
interface adau_spi_master_if;
    logic [31:0] command;
    logic        command_valid;
    logic        spi_ready;
    logic        busy;
    logic [7:0]  rdata;
    logic        rdata_valid;

    modport master (
        output command, command_valid,
        input  spi_ready, busy, rdata, rdata_valid
    );

    modport slave (
        input  command, command_valid,
        output spi_ready, busy, rdata, rdata_valid
    );
endinterface

// File: rtl/adau_spi_master.sv
// SPI control-port master for the ADAU1761: 32-bit frames MSB-first, framed by CLATCH.
// Optional readback of the last data byte on cout when ADAU_SPI_READBACK_EN is defined.
module adau_spi_master #(
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned LATCH_GAP = 8
) (
    input  logic               clk,
    input  logic               reset,
    adau_spi_master_if.slave   bus,
    output logic               cclk,
    output logic               clatch_n,
    output logic               cdata,
    input  logic               cout
);

    localparam int unsigned CMAX = (CLK_DIV > LATCH_GAP) ? CLK_DIV : LATCH_GAP;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(LATCH_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic          phase_q, phase_d;
    logic [31:0]   sh_q, sh_d;
    logic          cclk_q, cclk_d;
    logic          clatch_n_q, clatch_n_d;
    logic          cdata_q, cdata_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          div_last;
    logic          rise_now;

`ifdef ADAU_SPI_READBACK_EN
    logic       rw_q, rw_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d;
`endif

    assign div_last = (cnt_q == DIV_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        phase_d  = phase_q;
        sh_d     = sh_q;
        ready_d  = 1'b0;
        rise_now = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.command_valid) begin
                    sh_d    = bus.command;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    bit_d   = 5'd31;
                end
            end
            SHIFT: begin
                if (div_last) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d  = 1'b1;
                        rise_now = 1'b1;
                    end else if (bit_q == 5'd0) begin
                        state_d = HOLD;
                        phase_d = 1'b0;
                    end else begin
                        // data advances only on the falling cclk
                        bit_d   = bit_q - 5'd1;
                        phase_d = 1'b0;
                        sh_d    = {sh_q[30:0], 1'b0};
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                ready_d = (cnt_q == '0);
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pin values follow the next state so every output comes straight from a flop
        cclk_d     = (state_d == SHIFT) && phase_d;
        clatch_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        cdata_d    = clatch_n_d ? 1'b0 : sh_d[31];
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            phase_q    <= 1'b0;
            sh_q       <= '0;
            cclk_q     <= 1'b0;
            clatch_n_q <= 1'b1;
            cdata_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            sh_q       <= sh_d;
            cclk_q     <= cclk_d;
            clatch_n_q <= clatch_n_d;
            cdata_q    <= cdata_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

`ifdef ADAU_SPI_READBACK_EN
    always_comb begin
        rw_d     = rw_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (state_q == IDLE && bus.command_valid) begin
            rw_d = bus.command[24];
        end
        if (rise_now && (bit_q < 5'd8)) begin
            rx_d = {rx_q[6:0], cout};
        end
        if (ready_d && rw_q) begin
            rdata_d  = rx_q;
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q     <= 1'b0;
            rx_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rw_q     <= rw_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
`else
    logic unused_readback;
    assign unused_readback = cout ^ rise_now;
    assign bus.rdata       = 8'h00;
    assign bus.rdata_valid = 1'b0;
`endif

    assign bus.spi_ready = ready_q;
    assign bus.busy      = busy_q;
    assign cclk          = cclk_q;
    assign clatch_n      = clatch_n_q;
    assign cdata         = cdata_q;

endmodule

// File: tb/tb_adau_spi_master.sv
// Directed bench for adau_spi_master at CLK_DIV=2, LATCH_GAP=4; a negedge bus
// monitor reconstructs frames, and a small codec model drives cout.
module tb_adau_spi_master;

    logic clk = 1'b0;
    logic reset;
    logic cout;
    logic cclk, clatch_n, cdata;
    logic [7:0] cbyte = 8'h00;

    adau_spi_master_if bus ();

    adau_spi_master #(.CLK_DIV(2), .LATCH_GAP(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cclk     (cclk),
        .clatch_n (clatch_n),
        .cdata    (cdata),
        .cout     (cout)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus monitor, sampled on the falling clock edge
    int unsigned cyc = 0;
    logic p_cl = 1'b1, p_cclk = 1'b0, p_rdy = 1'b0, p_busy = 1'b0;
    logic [31:0] sh = '0;
    int unsigned low_cnt = 0, rises = 0, since = 0;
    logic [31:0] fr_bits[$];
    int unsigned fr_low[$], fr_rise[$], rdy_delay[$], acc_t[$];
    int unsigned rdy_cnt = 0, dbl_rdy = 0, idle_act = 0, rv_cnt = 0, rv_rdy = 0;

    always @(negedge clk) begin
        cyc++;
        if (!clatch_n && p_cl) begin
            sh = '0; low_cnt = 0; rises = 0;
        end
        if (!clatch_n) low_cnt++;
        if (cclk && !p_cclk) begin
            rises++;
            sh = {sh[30:0], cdata};
        end
        if (clatch_n && !p_cl) begin
            fr_bits.push_back(sh);
            fr_low.push_back(low_cnt);
            fr_rise.push_back(rises);
            since = 0;
        end else begin
            since++;
        end
        if (bus.spi_ready) begin
            rdy_cnt++;
            rdy_delay.push_back(since);
            if (p_rdy) dbl_rdy++;
        end
        if (bus.rdata_valid) begin
            rv_cnt++;
            if (bus.spi_ready) rv_rdy++;
        end
        if (bus.busy && !p_busy) acc_t.push_back(cyc);
        if (!clatch_n || cclk || bus.spi_ready || bus.busy) idle_act++;
        p_cl = clatch_n; p_cclk = cclk; p_rdy = bus.spi_ready; p_busy = bus.busy;
    end

    // Codec model: presents cbyte MSB-first so bit k is stable at the k-th data rise
    initial begin
        int unsigned n;
        int unsigned idx;
        n = 0;
        cout = 1'b0;
        forever begin
            @(cclk or clatch_n);
            if (clatch_n) n = 0;
            else if (cclk) n++;
            idx = 31 - n;
            cout = (!clatch_n && n < 32 && idx < 8) ? cbyte[idx] : 1'b0;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        fr_bits.delete(); fr_low.delete(); fr_rise.delete();
        rdy_delay.delete(); acc_t.delete();
        rdy_cnt = 0; dbl_rdy = 0; idle_act = 0; rv_cnt = 0; rv_rdy = 0; rises = 0;
    endtask

    task automatic wait_frames(input int unsigned n);
        int unsigned t = 0;
        while (fr_bits.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (8) @(negedge clk);
        chk("frame_count", fr_bits.size(), n);
    endtask

    task automatic send_one(input logic [31:0] w);
        bus.command = w;
        bus.command_valid = 1'b1;
        @(posedge clk); #1;
        bus.command_valid = 1'b0;
    endtask

    logic [31:0] wl [15] = '{
        32'h00000000, 32'h00000000, 32'h00000000, 32'h00400001,
        32'h00400A01, 32'h00400B05, 32'h00401501, 32'h00401C21,
        32'h00401E41, 32'h00402303, 32'h00402403, 32'h00402901,
        32'h00402A03, 32'h00401903, 32'h0040FA01
    };

    initial begin
        int unsigned t;
        reset = 1'b1;
        bus.command = '0;
        bus.command_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cclk", cclk, 0);
        chk("rst_clatch_n", clatch_n, 1);
        chk("rst_cdata", cdata, 0);
        chk("rst_spi_ready", bus.spi_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_rdata_valid", bus.rdata_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Idle bus with no command
        clear_mon();
        repeat (500) @(negedge clk);
        chk("idle_activity", idle_act, 0);
        chk("idle_ready", rdy_cnt, 0);

        // Single write
        clear_mon();
        send_one(32'h00400001);
        wait_frames(1);
        chk("single_bits", fr_bits[0], 32'h00400001);
        chk("single_latch_low", fr_low[0], 132);
        chk("single_rises", fr_rise[0], 32);
        chk("single_ready_cnt", rdy_cnt, 1);
        chk("single_ready_delay", rdy_delay[0], 1);
        chk("single_rdata", bus.rdata, 0);
        chk("single_rvalid_cnt", rv_cnt, 0);
        chk("single_busy_end", bus.busy, 0);

        // Command overwritten mid-frame
        clear_mon();
        bus.command = 32'h12345678;
        bus.command_valid = 1'b1;
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        bus.command = 32'hFFFFFFFF;
        bus.command_valid = 1'b0;
        wait_frames(1);
        chk("midchg_bits", fr_bits[0], 32'h12345678);
        chk("midchg_ready_cnt", rdy_cnt, 1);

        // 15-word init list from a sequencer that advances on spi_ready
        clear_mon();
        bus.command = wl[0];
        bus.command_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            t = 0;
            @(negedge clk);
            while (!bus.spi_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk("seq_ready_seen", bus.spi_ready, 1);
            @(posedge clk); #1;
            if (i < 14) bus.command = wl[i+1];
            else bus.command_valid = 1'b0;
        end
        wait_frames(15);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("seq_bits_%0d", i), fr_bits[i], wl[i]);
            chk($sformatf("seq_low_%0d", i), fr_low[i], 132);
        end
        chk("seq_accepts", acc_t.size(), 15);
        for (int i = 1; i < 15; i++)
            chk($sformatf("seq_period_%0d", i), acc_t[i] - acc_t[i-1], 137);
        chk("seq_ready_cnt", rdy_cnt, 15);
        chk("seq_ready_double", dbl_rdy, 0);

        // Reset at bit 10 aborts the frame
        clear_mon();
        send_one(32'hDEADBEEF);
        t = 0;
        while (rises != 22 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        chk("rst_reach_bit10", rises, 22);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_clatch_n", clatch_n, 1);
        chk("abort_cclk", cclk, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_no_ready", rdy_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_mon();
        send_one(32'hA5C30F81);
        wait_frames(1);
        chk("after_rst_bits", fr_bits[0], 32'hA5C30F81);
        chk("after_rst_rises", fr_rise[0], 32);
        chk("after_rst_ready", rdy_cnt, 1);

`ifdef ADAU_SPI_READBACK_EN
        clear_mon();
        cbyte = 8'hA5;
        send_one(32'h01400000);
        wait_frames(1);
        chk("rb_rdata", bus.rdata, 8'hA5);
        chk("rb_rvalid_cnt", rv_cnt, 1);
        chk("rb_rvalid_with_ready", rv_rdy, 1);
        clear_mon();
        cbyte = 8'h3C;
        send_one(32'h00400001);
        wait_frames(1);
        chk("rb_write_keeps_rdata", bus.rdata, 8'hA5);
        chk("rb_write_no_rvalid", rv_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
